pipeline_debug_controller: RTL and testbench

PIPELINE_DEBUG_CONTROLLER -- requirements
Module: pipeline_debug_controller

---
 rtl/pipeline_debug_controller.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_pipeline_debug_controller.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_debug_controller.sv
// -----------------------------------------------------------------------------
// pipeline_debug_controller
//
// Byte-oriented debug front end for a five-stage pipeline. Commands arrive as
// single received bytes:
//   'L' : reset the pipeline and load a program. Next byte = word count N,
//         then 4*N bytes (MSB first), one instruction-memory write per word.
//   'C' : run until the pipeline reports i_end, then dump state.
//   'S' : release the pipeline for a single clock, then dump state.
//   'D' : dump state immediately.
// A dump sends the concatenated inter-stage latches, the 32 registers and
// DATA_MEM_WORDS data-memory words, all MSB first, over a valid/ready byte port.
//
// Ports
//   i_clk / i_reset            : clock (rising edge) / asynchronous active-low reset
//   i_rx_data, i_rx_valid      : received byte and its one-cycle strobe
//   o_tx_data, o_tx_valid,
//   i_tx_ready                 : outgoing byte stream (valid/ready handshake)
//   o_stop, o_pipe_reset       : pipeline freeze level and one-cycle reset pulse
//   o_write_instruction_mem,
//   o_instruction_mem_addr/data: program load write port
//   o_r_addr_registers,
//   i_r_data_registers         : register-file debug read port
//   o_r_addr_data_mem,
//   i_r_data_data_mem          : data-memory debug read port
//   i_IF_ID .. i_MEM_WB        : pipeline latch snapshots
//   i_end                      : pipeline has halted
//   o_busy                     : controller is not idle
// -----------------------------------------------------------------------------
module pipeline_debug_controller #(
    parameter int NB_IF_ID       = 64,
    parameter int NB_ID_EX       = 168,
    parameter int NB_EX_MEM      = 88,
    parameter int NB_MEM_WB      = 80,
    parameter int DATA_MEM_WORDS = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_valid,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic                 o_stop,
    output logic                 o_pipe_reset,
    output logic                 o_write_instruction_mem,
    output logic [31:0]          o_instruction_mem_addr,
    output logic [31:0]          o_instruction_mem_data,
    output logic [4:0]           o_r_addr_registers,
    input  logic [31:0]          i_r_data_registers,
    output logic [31:0]          o_r_addr_data_mem,
    input  logic [31:0]          i_r_data_data_mem,
    input  logic [NB_IF_ID-1:0]  i_IF_ID,
    input  logic [NB_ID_EX-1:0]  i_ID_EX,
    input  logic [NB_EX_MEM-1:0] i_EX_MEM,
    input  logic [NB_MEM_WB-1:0] i_MEM_WB,
    input  logic                 i_end,
    output logic                 o_busy
);

    localparam int NB_TOTAL    = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
    localparam int LATCH_BYTES = NB_TOTAL / 8;
    localparam int BIDX_W      = (LATCH_BYTES > 4) ? $clog2(LATCH_BYTES + 1) : 3;

    localparam logic [BIDX_W-1:0] LATCH_BYTES_C = BIDX_W'(LATCH_BYTES);
    localparam logic [BIDX_W-1:0] WORD_BYTES_C  = BIDX_W'(4);
    localparam logic [31:0]       LAST_MEM_ADDR = 32'((DATA_MEM_WORDS - 1) * 4);

    typedef enum logic [3:0] {
        IDLE,
        LOAD_COUNT,
        LOAD_BYTES,
        LOAD_WRITE,
        RUN,
        STEP,
        DUMP_LATCH,
        DUMP_REG,
        DUMP_MEM
    } state_t;

    state_t              state_q, state_d;
    logic                stop_q, stop_d;
    logic                pipeReset_q, pipeReset_d;
    logic                writeIm_q, writeIm_d;
    logic [31:0]         imAddr_q, imAddr_d;
    logic [31:0]         asm_q, asm_d;
    logic [7:0]          wordCount_q, wordCount_d;
    logic [7:0]          wordIdx_q, wordIdx_d;
    logic [1:0]          byteCnt_q, byteCnt_d;
    logic [NB_TOTAL-1:0] shift_q, shift_d;
    logic [BIDX_W-1:0]   byteIdx_q, byteIdx_d;
    logic                txValid_q, txValid_d;
    logic [7:0]          txData_q, txData_d;
    logic [4:0]          regAddr_q, regAddr_d;
    logic [31:0]         memAddr_q, memAddr_d;
    logic [31:0]         word_q, word_d;
    logic                loaded_q, loaded_d;
    logic                canLoad;

    // All outputs come straight from registers, so nothing moves after reset
    // until a command byte changes the state.
    assign o_tx_data               = txData_q;
    assign o_tx_valid              = txValid_q;
    assign o_stop                  = stop_q;
    assign o_pipe_reset            = pipeReset_q;
    assign o_write_instruction_mem = writeIm_q;
    assign o_instruction_mem_addr  = imAddr_q;
    assign o_instruction_mem_data  = asm_q;
    assign o_r_addr_registers      = regAddr_q;
    assign o_r_addr_data_mem       = memAddr_q;
    assign o_busy                  = (state_q != IDLE);

    // A new byte may be placed on the tx port when the slot is empty or the
    // byte currently offered is being accepted this cycle.
    assign canLoad = !txValid_q || i_tx_ready;

    // Next-state logic. o_stop is registered and decided on the transition
    // into RUN/STEP: if i_end is already high there, the pipeline is never
    // released. The read ports are given one cycle (loaded_q low) between an
    // address change and sampling of the returned data.
    always_comb begin
        state_d     = state_q;
        stop_d      = stop_q;
        pipeReset_d = 1'b0;
        writeIm_d   = 1'b0;
        imAddr_d    = imAddr_q;
        asm_d       = asm_q;
        wordCount_d = wordCount_q;
        wordIdx_d   = wordIdx_q;
        byteCnt_d   = byteCnt_q;
        shift_d     = shift_q;
        byteIdx_d   = byteIdx_q;
        txValid_d   = txValid_q;
        txData_d    = txData_q;
        regAddr_d   = regAddr_q;
        memAddr_d   = memAddr_q;
        word_d      = word_q;
        loaded_d    = loaded_q;

        if (txValid_q && i_tx_ready) begin
            txValid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        8'h4C: begin
                            state_d     = LOAD_COUNT;
                            pipeReset_d = 1'b1;
                        end
                        8'h43: begin
                            state_d = RUN;
                            stop_d  = i_end;
                        end
                        8'h53: begin
                            state_d = STEP;
                            stop_d  = i_end;
                        end
                        8'h44: state_d = DUMP_LATCH;
                        default: ;
                    endcase
                end
            end
            LOAD_COUNT: begin
                if (i_rx_valid) begin
                    if (i_rx_data == 8'h00) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = LOAD_BYTES;
                        wordCount_d = i_rx_data;
                        wordIdx_d   = 8'h00;
                        imAddr_d    = 32'h0;
                        byteCnt_d   = 2'd0;
                    end
                end
            end
            LOAD_BYTES: begin
                if (i_rx_valid) begin
                    asm_d     = {asm_q[23:0], i_rx_data};
                    byteCnt_d = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'd3) begin
                        state_d   = LOAD_WRITE;
                        writeIm_d = 1'b1;
                    end
                end
            end
            LOAD_WRITE: begin
                imAddr_d  = imAddr_q + 32'd4;
                wordIdx_d = wordIdx_q + 8'd1;
                if (wordIdx_q == wordCount_q - 8'd1) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOAD_BYTES;
                end
            end
            RUN: begin
                if (i_end) begin
                    state_d = DUMP_LATCH;
                    stop_d  = 1'b1;
                end
            end
            STEP: begin
                state_d = DUMP_LATCH;
                stop_d  = 1'b1;
            end
            DUMP_LATCH: begin
                if (canLoad) begin
                    if (byteIdx_q != LATCH_BYTES_C) begin
                        txData_d  = shift_q[NB_TOTAL-1 -: 8];
                        shift_d   = shift_q << 8;
                        txValid_d = 1'b1;
                        byteIdx_d = byteIdx_q + BIDX_W'(1);
                    end else begin
                        state_d   = DUMP_REG;
                        byteIdx_d = '0;
                        regAddr_d = 5'd0;
                        loaded_d  = 1'b0;
                    end
                end
            end
            DUMP_REG, DUMP_MEM: begin
                if (!loaded_q) begin
                    word_d    = (state_q == DUMP_REG) ? i_r_data_registers : i_r_data_data_mem;
                    loaded_d  = 1'b1;
                    byteIdx_d = '0;
                end else if (canLoad) begin
                    if (byteIdx_q != WORD_BYTES_C) begin
                        txData_d  = word_q[31:24];
                        word_d    = {word_q[23:0], 8'h00};
                        txValid_d = 1'b1;
                        byteIdx_d = byteIdx_q + BIDX_W'(1);
                    end else begin
                        loaded_d  = 1'b0;
                        byteIdx_d = '0;
                        if (state_q == DUMP_REG) begin
                            if (regAddr_q == 5'd31) begin
                                state_d   = DUMP_MEM;
                                regAddr_d = 5'd0;
                                memAddr_d = 32'h0;
                            end else begin
                                regAddr_d = regAddr_q + 5'd1;
                            end
                        end else begin
                            if (memAddr_q == LAST_MEM_ADDR) begin
                                state_d   = IDLE;
                                memAddr_d = 32'h0;
                            end else begin
                                memAddr_d = memAddr_q + 32'd4;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The latch snapshot is taken on the edge that enters the dump, while
        // the pipeline is frozen.
        if (state_d == DUMP_LATCH && state_q != DUMP_LATCH) begin
            shift_d   = {i_IF_ID, i_ID_EX, i_EX_MEM, i_MEM_WB};
            byteIdx_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            stop_q      <= 1'b1;
            pipeReset_q <= 1'b0;
            writeIm_q   <= 1'b0;
            imAddr_q    <= 32'h0;
            asm_q       <= 32'h0;
            wordCount_q <= 8'h00;
            wordIdx_q   <= 8'h00;
            byteCnt_q   <= 2'd0;
            shift_q     <= '0;
            byteIdx_q   <= '0;
            txValid_q   <= 1'b0;
            txData_q    <= 8'h00;
            regAddr_q   <= 5'd0;
            memAddr_q   <= 32'h0;
            word_q      <= 32'h0;
            loaded_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_q      <= stop_d;
            pipeReset_q <= pipeReset_d;
            writeIm_q   <= writeIm_d;
            imAddr_q    <= imAddr_d;
            asm_q       <= asm_d;
            wordCount_q <= wordCount_d;
            wordIdx_q   <= wordIdx_d;
            byteCnt_q   <= byteCnt_d;
            shift_q     <= shift_d;
            byteIdx_q   <= byteIdx_d;
            txValid_q   <= txValid_d;
            txData_q    <= txData_d;
            regAddr_q   <= regAddr_d;
            memAddr_q   <= memAddr_d;
            word_q      <= word_d;
            loaded_q    <= loaded_d;
        end
    end

endmodule

// File: tb/tb_pipeline_debug_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_debug_controller
//
// Directed bench for pipeline_debug_controller. The register file and data
// memory are modelled as combinational lookups driven from the DUT read
// addresses; the expected dump stream is rebuilt from the latch inputs and the
// same lookup functions. A monitor samples outputs 3 ns after each falling
// edge (well clear of the rising edge) and collects accepted tx bytes,
// instruction-memory writes, pipe-reset pulses and released-pipeline cycles.
// -----------------------------------------------------------------------------
module tb_pipeline_debug_controller;

    localparam int NB_IF_ID       = 64;
    localparam int NB_ID_EX       = 168;
    localparam int NB_EX_MEM      = 88;
    localparam int NB_MEM_WB      = 80;
    localparam int DATA_MEM_WORDS = 32;
    localparam int NB_TOTAL       = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
    localparam int DUMP_BYTES     = NB_TOTAL / 8 + 128 + 4 * DATA_MEM_WORDS;

    logic                 i_clk;
    logic                 i_reset;
    logic [7:0]           i_rx_data;
    logic                 i_rx_valid;
    logic [7:0]           o_tx_data;
    logic                 o_tx_valid;
    logic                 i_tx_ready;
    logic                 o_stop;
    logic                 o_pipe_reset;
    logic                 o_write_instruction_mem;
    logic [31:0]          o_instruction_mem_addr;
    logic [31:0]          o_instruction_mem_data;
    logic [4:0]           o_r_addr_registers;
    logic [31:0]          i_r_data_registers;
    logic [31:0]          o_r_addr_data_mem;
    logic [31:0]          i_r_data_data_mem;
    logic [NB_IF_ID-1:0]  i_IF_ID;
    logic [NB_ID_EX-1:0]  i_ID_EX;
    logic [NB_EX_MEM-1:0] i_EX_MEM;
    logic [NB_MEM_WB-1:0] i_MEM_WB;
    logic                 i_end;
    logic                 o_busy;

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0]  txq[$];
    logic [31:0] wrAddr[$];
    logic [31:0] wrData[$];
    int          stopLow    = 0;
    int          pipeResets = 0;
    int          holdErr    = 0;
    logic        prevPending = 1'b0;
    logic [7:0]  prevData    = 8'h00;
    logic        readyToggle = 1'b0;

    pipeline_debug_controller #(
        .NB_IF_ID      (NB_IF_ID),
        .NB_ID_EX      (NB_ID_EX),
        .NB_EX_MEM     (NB_EX_MEM),
        .NB_MEM_WB     (NB_MEM_WB),
        .DATA_MEM_WORDS(DATA_MEM_WORDS)
    ) dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_rx_data              (i_rx_data),
        .i_rx_valid             (i_rx_valid),
        .o_tx_data              (o_tx_data),
        .o_tx_valid             (o_tx_valid),
        .i_tx_ready             (i_tx_ready),
        .o_stop                 (o_stop),
        .o_pipe_reset           (o_pipe_reset),
        .o_write_instruction_mem(o_write_instruction_mem),
        .o_instruction_mem_addr (o_instruction_mem_addr),
        .o_instruction_mem_data (o_instruction_mem_data),
        .o_r_addr_registers     (o_r_addr_registers),
        .i_r_data_registers     (i_r_data_registers),
        .o_r_addr_data_mem      (o_r_addr_data_mem),
        .i_r_data_data_mem      (i_r_data_data_mem),
        .i_IF_ID                (i_IF_ID),
        .i_ID_EX                (i_ID_EX),
        .i_EX_MEM               (i_EX_MEM),
        .i_MEM_WB               (i_MEM_WB),
        .i_end                  (i_end),
        .o_busy                 (o_busy)
    );

    // Register file contents; register 3 holds the value the dump must show.
    function automatic logic [31:0] regVal(input logic [4:0] r);
        if (r == 5'd3) return 32'h12345678;
        return {3'b101, r, 8'h3C, 3'b010, r, 8'h99};
    endfunction

    // Data memory contents by byte address.
    function automatic logic [31:0] memVal(input logic [31:0] a);
        return 32'hD0000000 ^ (a * 32'h00010101);
    endfunction

    assign i_r_data_registers = regVal(o_r_addr_registers);
    assign i_r_data_data_mem  = memVal(o_r_addr_data_mem);

    // Expected k-th byte of a full dump.
    function automatic logic [7:0] expByte(input int k);
        logic [NB_TOTAL-1:0] full;
        logic [31:0]         w;
        int                  idx;
        full = {i_IF_ID, i_ID_EX, i_EX_MEM, i_MEM_WB};
        if (k < NB_TOTAL / 8) begin
            return full[NB_TOTAL - 1 - 8 * k -: 8];
        end else if (k < NB_TOTAL / 8 + 128) begin
            idx = k - NB_TOTAL / 8;
            w   = regVal(5'(idx / 4));
        end else begin
            idx = k - NB_TOTAL / 8 - 128;
            w   = memVal(32'(4 * (idx / 4)));
        end
        return w[31 - 8 * (idx % 4) -: 8];
    endfunction

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Receiver-side ready: held high, or toggled every cycle when requested.
    initial begin
        i_tx_ready = 1'b1;
        forever begin
            @(negedge i_clk);
            if (readyToggle) i_tx_ready = ~i_tx_ready;
            else             i_tx_ready = 1'b1;
        end
    end

    // Output monitor, sampling mid-cycle before the next rising edge.
    always @(negedge i_clk) begin
        #3;
        if (!i_reset) begin
            prevPending = 1'b0;
        end else begin
            if (prevPending && (!o_tx_valid || o_tx_data !== prevData)) holdErr++;
            if (o_tx_valid && i_tx_ready) txq.push_back(o_tx_data);
            prevPending = o_tx_valid && !i_tx_ready;
            prevData    = o_tx_data;
            if (!o_stop) stopLow++;
            if (o_pipe_reset) pipeResets++;
            if (o_write_instruction_mem) begin
                wrAddr.push_back(o_instruction_mem_addr);
                wrData.push_back(o_instruction_mem_data);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // One received byte: one-cycle strobe, then the given number of quiet cycles.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        @(negedge i_clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        repeat (gap) @(negedge i_clk);
    endtask

    task automatic clearMonitor();
        txq.delete();
        wrAddr.delete();
        wrData.delete();
        stopLow    = 0;
        pipeResets = 0;
        holdErr    = 0;
    endtask

    // Bounded wait for a complete dump and the return to idle.
    task automatic waitDump(input string tag);
        int budget;
        budget = 0;
        while ((txq.size() < DUMP_BYTES || o_busy) && budget < 5000) begin
            @(negedge i_clk);
            budget++;
        end
        @(negedge i_clk);
        #4;
        checkOutput({tag, "_idle"}, 64'(o_busy), 64'd0);
    endtask

    task automatic compareDump(input string tag);
        int mism;
        mism = 0;
        checkOutput({tag, "_count"}, 64'(txq.size()), 64'(DUMP_BYTES));
        if (txq.size() == DUMP_BYTES) begin
            for (int k = 0; k < DUMP_BYTES; k++) begin
                if (txq[k] !== expByte(k)) mism++;
            end
        end else begin
            mism = -1;
        end
        checkOutput({tag, "_bytes_wrong"}, 64'(mism), 64'd0);
        checkOutput({tag, "_hold_errors"}, 64'(holdErr), 64'd0);
    endtask

    initial begin
        logic [31:0] reg3;
        int          budget;

        i_reset    = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        i_end      = 1'b0;
        i_IF_ID    = 64'h0123456789ABCDEF;
        for (int i = 0; i < NB_ID_EX / 8; i++)  i_ID_EX[8*i +: 8]  = 8'(8'h40 + i);
        for (int i = 0; i < NB_EX_MEM / 8; i++) i_EX_MEM[8*i +: 8] = 8'(8'h80 + 3 * i);
        for (int i = 0; i < NB_MEM_WB / 8; i++) i_MEM_WB[8*i +: 8] = 8'(8'hE1 ^ i);

        // Reset state.
        repeat (2) @(negedge i_clk);
        #1;
        checkOutput("rst_stop",      64'(o_stop), 64'd1);
        checkOutput("rst_busy",      64'(o_busy), 64'd0);
        checkOutput("rst_tx_valid",  64'(o_tx_valid), 64'd0);
        checkOutput("rst_pipe_rst",  64'(o_pipe_reset), 64'd0);
        checkOutput("rst_addr_outs", {o_r_addr_data_mem, 27'd0, o_r_addr_registers}, 64'd0);

        // Quiet after release.
        @(negedge i_clk);
        i_reset = 1'b1;
        repeat (4) @(negedge i_clk);
        #1;
        checkOutput("post_rst_stop",  64'(o_stop), 64'd1);
        checkOutput("post_rst_busy",  64'(o_busy), 64'd0);
        checkOutput("post_rst_write", {o_instruction_mem_addr, 31'd0, o_write_instruction_mem}, 64'd0);

        // Two-word program load.
        clearMonitor();
        applyStimulus(8'h4C, 2);
        applyStimulus(8'h02, 2);
        applyStimulus(8'h20, 2);
        applyStimulus(8'h08, 2);
        applyStimulus(8'h00, 2);
        applyStimulus(8'h05, 2);
        applyStimulus(8'hFC, 2);
        applyStimulus(8'h00, 2);
        applyStimulus(8'h00, 2);
        applyStimulus(8'h00, 3);
        checkOutput("load_pipe_resets", 64'(pipeResets), 64'd1);
        checkOutput("load_write_cycles", 64'(wrAddr.size()), 64'd2);
        if (wrAddr.size() == 2) begin
            checkOutput("load_w0", {wrAddr[0], wrData[0]}, {32'h0, 32'h20080005});
            checkOutput("load_w1", {wrAddr[1], wrData[1]}, {32'h4, 32'hFC000000});
        end
        checkOutput("load_busy_end", 64'(o_busy), 64'd0);

        // Zero-word load.
        clearMonitor();
        applyStimulus(8'h4C, 2);
        applyStimulus(8'h00, 0);
        @(negedge i_clk);
        #1;
        checkOutput("zero_busy", 64'(o_busy), 64'd0);
        repeat (3) @(negedge i_clk);
        checkOutput("zero_writes", 64'(wrAddr.size()), 64'd0);
        checkOutput("zero_pipe_resets", 64'(pipeResets), 64'd1);

        // Single step, then full dump.
        clearMonitor();
        applyStimulus(8'h53, 0);
        waitDump("step");
        checkOutput("step_stop_low", 64'(stopLow), 64'd1);
        checkOutput("step_first_byte", 64'((txq.size() > 0) ? txq[0] : 8'hXX), 64'h01);
        compareDump("step");

        // Continue with i_end rising after 10 released cycles; an 'L' arriving
        // mid-run must be ignored.
        clearMonitor();
        applyStimulus(8'h43, 0);
        @(negedge i_clk);
        i_rx_data  = 8'h4C;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        repeat (7) @(negedge i_clk);
        i_end = 1'b1;
        waitDump("run");
        i_end = 1'b0;
        checkOutput("run_stop_low", 64'(stopLow), 64'd10);
        checkOutput("run_rx_ignored", 64'(pipeResets), 64'd0);
        reg3 = (txq.size() >= 66) ? {txq[62], txq[63], txq[64], txq[65]} : 32'h0;
        checkOutput("run_reg3_bytes", 64'(reg3), 64'h12345678);
        compareDump("run");

        // Dump with the receiver stalling every other cycle.
        clearMonitor();
        readyToggle = 1'b1;
        applyStimulus(8'h44, 0);
        waitDump("toggle");
        readyToggle = 1'b0;
        checkOutput("toggle_stop_low", 64'(stopLow), 64'd0);
        compareDump("toggle");

        // Reset during the register section, then a fresh dump.
        clearMonitor();
        applyStimulus(8'h44, 0);
        budget = 0;
        while (txq.size() < 60 && budget < 2000) begin
            @(negedge i_clk);
            budget++;
        end
        checkOutput("midrst_reached", 64'(txq.size() >= 60), 64'd1);
        i_reset = 1'b0;
        #1;
        checkOutput("midrst_tx_valid", 64'(o_tx_valid), 64'd0);
        checkOutput("midrst_busy",     64'(o_busy), 64'd0);
        checkOutput("midrst_stop_addr", {31'd0, o_stop, 27'd0, o_r_addr_registers}, {31'd0, 1'b1, 32'd0});
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        clearMonitor();
        applyStimulus(8'h44, 0);
        waitDump("fresh");
        compareDump("fresh");

        $display("[TB] directed sequence complete");
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
